// File: rtl/ipid_gpio_receiver.sv
// Polls IPIDs from a host over GPIO: trigger per index, then read a header, payload and trailer.
// Optional IPID_RETRY_EN: failed frames are retried up to 3 times per IP before aborting.
module ipid_gpio_receiver #(
    parameter int unsigned IPID_N         = 16,
    parameter int unsigned WORD_W         = 16,
    parameter int unsigned IPID_WIDTH     = 256,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  ipid_valid_in,
    input  logic [WORD_W-1:0]     ipid_word_in,
    output logic                  ipid_trigger_out,
    output logic [3:0]            ipid_addr_out,
    output logic [IPID_WIDTH-1:0] id_out,
    output logic [3:0]            id_idx_out,
    output logic                  id_valid_out,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code
);

    localparam int unsigned NWords = IPID_WIDTH / WORD_W;
    localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned WrdW   = $clog2(NWords);
    localparam int unsigned CntW   = (TmoW > WrdW) ? TmoW : WrdW;

    localparam logic [WORD_W-1:0] Header      = WORD_W'(16'h7A7A);
    localparam logic [WORD_W-1:0] Trailer     = WORD_W'(16'hB9B9);
    localparam logic [CntW-1:0]   CntTmo      = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0]   CntLastWord = CntW'(NWords - 1);
    localparam logic [3:0]        LastAddr    = 4'(IPID_N - 1);

    typedef enum logic [2:0] {
        StIdle, StTrig, StPayload, StTrail, StRelease, StGap, StDone, StErr
    } state_e;

    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [3:0]            addr_q;
    logic                  trig_q;
    logic [IPID_WIDTH-1:0] cap_q;
    logic [IPID_WIDTH-1:0] id_q;
    logic [3:0]            idx_q;
    logic                  id_valid_q;
    logic                  done_q;
    logic                  error_q;
    logic [1:0]            err_code_q;
`ifdef IPID_RETRY_EN
    logic [1:0]            retry_q;
    logic                  retry_pend_q;
`endif

    logic       fail;
    logic [1:0] fail_code;

    // Frame protocol violations and timeouts, decoded from the current state.
    always_comb begin
        fail      = 1'b0;
        fail_code = 2'b00;
        unique case (state_q)
            StTrig: begin
                if (ipid_valid_in && ipid_word_in != Header) begin
                    fail      = 1'b1;
                    fail_code = 2'b01;
                end else if (!ipid_valid_in && cnt_q == CntTmo) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end
            end
            StPayload: begin
                if (!ipid_valid_in) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            StTrail: begin
                if (!(ipid_valid_in && ipid_word_in == Trailer)) begin
                    fail      = 1'b1;
                    fail_code = 2'b10;
                end
            end
            StRelease: begin
                if (ipid_valid_in && cnt_q == CntTmo) begin
                    fail      = 1'b1;
                    fail_code = 2'b11;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            addr_q     <= '0;
            trig_q     <= 1'b0;
            cap_q      <= '0;
            id_q       <= '0;
            idx_q      <= '0;
            id_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= 2'b00;
`ifdef IPID_RETRY_EN
            retry_q      <= 2'd0;
            retry_pend_q <= 1'b0;
`endif
        end else begin
            id_valid_q <= 1'b0;
            if (fail) begin
                trig_q <= 1'b0;
                cnt_q  <= '0;
`ifdef IPID_RETRY_EN
                if (retry_q != 2'd3) begin
                    // Let the host release valid, then re-request the same index.
                    retry_q      <= retry_q + 2'd1;
                    retry_pend_q <= 1'b1;
                    state_q      <= StRelease;
                end else begin
                    state_q    <= StErr;
                    error_q    <= 1'b1;
                    err_code_q <= fail_code;
                end
`else
                state_q    <= StErr;
                error_q    <= 1'b1;
                err_code_q <= fail_code;
`endif
            end else begin
                unique case (state_q)
                    StIdle, StDone, StErr: begin
                        if (start) begin
                            state_q    <= StTrig;
                            trig_q     <= 1'b1;
                            cnt_q      <= '0;
                            addr_q     <= '0;
                            done_q     <= 1'b0;
                            error_q    <= 1'b0;
                            err_code_q <= 2'b00;
`ifdef IPID_RETRY_EN
                            retry_q      <= 2'd0;
                            retry_pend_q <= 1'b0;
`endif
                        end
                    end
                    StTrig: begin
                        if (ipid_valid_in) begin
                            state_q <= StPayload;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StPayload: begin
                        // First word shifts all the way up to the MSBs.
                        cap_q <= {cap_q[IPID_WIDTH-WORD_W-1:0], ipid_word_in};
                        if (cnt_q == CntLastWord) begin
                            state_q <= StTrail;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StTrail: begin
                        state_q    <= StRelease;
                        trig_q     <= 1'b0;
                        cnt_q      <= '0;
                        id_q       <= cap_q;
                        idx_q      <= addr_q;
                        id_valid_q <= 1'b1;
`ifdef IPID_RETRY_EN
                        retry_q <= 2'd0;
`endif
                    end
                    StRelease: begin
                        if (!ipid_valid_in) begin
                            cnt_q <= '0;
`ifdef IPID_RETRY_EN
                            if (retry_pend_q) begin
                                retry_pend_q <= 1'b0;
                                state_q      <= StGap;
                            end else
`endif
                            if (addr_q == LastAddr) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                addr_q  <= addr_q + 4'd1;
                                state_q <= StGap;
                            end
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StGap: begin
                        state_q <= StTrig;
                        trig_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign ipid_trigger_out = trig_q;
    assign ipid_addr_out    = addr_q;
    assign id_out           = id_q;
    assign id_idx_out       = idx_q;
    assign id_valid_out     = id_valid_q;
    assign done             = done_q;
    assign error            = error_q;
    assign err_code         = err_code_q;

endmodule

// File: tb/tb_ipid_gpio_receiver.sv
// Bench for ipid_gpio_receiver: behavioural host drives frames, expected IDs built from payload.
module tb_ipid_gpio_receiver;

    localparam int unsigned TO = 1024;
    localparam logic [15:0] Hdr = 16'h7A7A;
    localparam logic [15:0] Trl = 16'hB9B9;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         valid = 1'b0;
    logic [15:0]  word = 16'h0;
    logic         trig;
    logic [3:0]   addr;
    logic [255:0] id;
    logic [3:0]   idx;
    logic         idv;
    logic         done;
    logic         error;
    logic [1:0]   err_code;

    int tests = 0;
    int fails = 0;
    int pulses = 0;
    logic [255:0] got_id[$];
    logic [3:0]   got_idx[$];
    logic [15:0]  pay[16];
    logic [255:0] exp_id[16];

    ipid_gpio_receiver #(
        .IPID_N(16), .WORD_W(16), .IPID_WIDTH(256), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .ipid_valid_in(valid), .ipid_word_in(word),
        .ipid_trigger_out(trig), .ipid_addr_out(addr),
        .id_out(id), .id_idx_out(idx), .id_valid_out(idv),
        .done(done), .error(error), .err_code(err_code)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (idv) begin
            pulses++;
            got_id.push_back(id);
            got_idx.push_back(idx);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: observed no end, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        pulses = 0;
        got_id.delete();
        got_idx.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_trig(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (trig === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
        end
        check("trig_wait", 256'(0), 256'(1));
    endtask

    // Random payload and the ID it must produce: word 0 in the top 16 bits.
    task automatic gen_payload(input int a);
        logic [255:0] e;
        e = '0;
        for (int i = 0; i < 16; i++) begin
            pay[i] = 16'($urandom);
            e[255 - 16*i -: 16] = pay[i];
        end
        exp_id[a] = e;
    endtask

    // Header, n_pay payload words, trailer only if the payload is complete, then release.
    task automatic send_frame(input logic [15:0] hdr, input int n_pay, input logic [15:0] trl);
        bit ok;
        wait_trig(ok);
        if (!ok) return;
        valid = 1'b1;
        word = hdr;
        @(negedge clk);
        for (int i = 0; i < n_pay; i++) begin
            word = pay[i];
            @(negedge clk);
        end
        if (n_pay == 16) begin
            word = trl;
            @(negedge clk);
        end
        valid = 1'b0;
        word = 16'($urandom);
        @(negedge clk);
    endtask

    task automatic run_good(input int first, input int last);
        for (int a = first; a <= last; a++) begin
            gen_payload(a);
            send_frame(Hdr, 16, Trl);
        end
    endtask

    task automatic check_sweep(input string tag);
        check({tag, "_pulses"}, 256'(pulses), 256'(16));
        for (int i = 0; i < 16; i++) begin
            if (got_id.size() == 0) break;
            check({tag, "_id"}, got_id.pop_front(), exp_id[i]);
            check({tag, "_idx"}, 256'(got_idx.pop_front()), 256'(i));
        end
        check({tag, "_done"}, 256'(done), 256'(1));
        check({tag, "_error"}, 256'(error), 256'(0));
        check({tag, "_trig"}, 256'(trig), 256'(0));
    endtask

    task automatic run_sweep(input string tag);
        clear_mon();
        pulse_start();
        run_good(0, 15);
        check_sweep(tag);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_trig"}, 256'(trig), 256'(0));
        check({tag, "_addr"}, 256'(addr), 256'(0));
        check({tag, "_id"}, id, 256'(0));
        check({tag, "_idx"}, 256'(idx), 256'(0));
        check({tag, "_idv"}, 256'(idv), 256'(0));
        check({tag, "_done"}, 256'(done), 256'(0));
        check({tag, "_error"}, 256'(error), 256'(0));
        check({tag, "_code"}, 256'(err_code), 256'(0));
    endtask

    initial begin
        bit ok;
        int n;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_sweep("sweep1");

`ifdef IPID_RETRY_EN
        // Bad trailer at index 2 is retried; sweep still completes.
        clear_mon();
        pulse_start();
        run_good(0, 1);
        gen_payload(2);
        send_frame(Hdr, 16, 16'hB9B8);
        check("retry_error", 256'(error), 256'(0));
        check("retry_addr", 256'(addr), 256'(2));
        wait_trig(ok);
        check("retry_trig_addr", 256'(addr), 256'(2));
        run_good(2, 15);
        check_sweep("retry");
`else
        // Corrupted header at index 3.
        clear_mon();
        pulse_start();
        run_good(0, 2);
        send_frame(16'h7A7B, 0, 16'h0);
        check("hdr_error", 256'(error), 256'(1));
        check("hdr_code", 256'(err_code), 256'(1));
        check("hdr_addr", 256'(addr), 256'(3));
        check("hdr_trig", 256'(trig), 256'(0));
        check("hdr_done", 256'(done), 256'(0));
        check("hdr_pulses", 256'(pulses), 256'(3));

        // Valid released after payload word 9 of index 0.
        clear_mon();
        pulse_start();
        check("rearm_error", 256'(error), 256'(0));
        gen_payload(0);
        send_frame(Hdr, 9, 16'h0);
        check("short_error", 256'(error), 256'(1));
        check("short_code", 256'(err_code), 256'(2));
        check("short_addr", 256'(addr), 256'(0));
        check("short_pulses", 256'(pulses), 256'(0));

        // Host never answers the trigger.
        pulse_start();
        wait_trig(ok);
        n = 1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (error === 1'b1) break;
            n++;
        end
        check("tmo_cycles", 256'(n), 256'(TO));
        check("tmo_code", 256'(err_code), 256'(3));
        check("tmo_trig", 256'(trig), 256'(0));
`endif

        // Reset in the middle of index 5's payload, with start and valid held high.
        clear_mon();
        pulse_start();
        run_good(0, 4);
        gen_payload(5);
        wait_trig(ok);
        check("rst_pre_addr", 256'(addr), 256'(5));
        valid = 1'b1;
        word = Hdr;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            word = pay[i];
            @(negedge clk);
        end
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        start = 1'b0;
        repeat (4) @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
        check("norsm_trig", 256'(trig), 256'(0));
        check("norsm_idv_cnt", 256'(pulses), 256'(5));
        run_sweep("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
